// File: rtl/button_event_decoder.sv
// Turns a debounced button (level + click pulse) into short/long/repeat events.
// Optional double-click detection is compiled in with `define BTN_DOUBLE_CLICK_EN.
module button_event_decoder #(
    parameter int unsigned CNT_WIDTH     = 16,
    parameter int unsigned LONG_CYCLES   = 1000,
    parameter int unsigned REPEAT_CYCLES = 200,
    parameter int unsigned DBL_WINDOW    = 300
) (
    input  logic clk,
    input  logic rst,
    input  logic ce,
    input  logic btn_level,
    input  logic btn_click,
    output logic short_press,
    output logic long_press,
    output logic repeat_tick,
    output logic double_press,
    output logic held
);

`ifdef BTN_DOUBLE_CLICK_EN
    typedef enum logic [2:0] {IDLE, PRESSED, LONG, WAIT2, SWALLOW} state_t;
`else
    typedef enum logic [2:0] {IDLE, PRESSED, LONG} state_t;
    logic unused_dbl_window;
    assign unused_dbl_window = |CNT_WIDTH'(DBL_WINDOW);
`endif

    state_t               state;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_inc;

    assign cnt_inc = cnt + CNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_tick  <= 1'b0;
            double_press <= 1'b0;
            held         <= 1'b0;
        end else begin
            // pulses live for exactly one clk, independent of ce
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            repeat_tick  <= 1'b0;
            double_press <= 1'b0;
            if (ce) begin
                case (state)
                    IDLE: begin
                        if (btn_click) begin
                            state <= PRESSED;
                            cnt   <= '0;
                        end
                    end
                    PRESSED: begin
                        if (!btn_level) begin
                            cnt <= '0;
`ifdef BTN_DOUBLE_CLICK_EN
                            state <= WAIT2;
`else
                            state       <= IDLE;
                            short_press <= 1'b1;
`endif
                        end else if (cnt_inc == CNT_WIDTH'(LONG_CYCLES)) begin
                            state      <= LONG;
                            cnt        <= '0;
                            long_press <= 1'b1;
                            held       <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    LONG: begin
                        if (!btn_level) begin
                            state <= IDLE;
                            cnt   <= '0;
                            held  <= 1'b0;
                        end else if (cnt_inc == CNT_WIDTH'(REPEAT_CYCLES)) begin
                            cnt         <= '0;
                            repeat_tick <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
`ifdef BTN_DOUBLE_CLICK_EN
                    WAIT2: begin
                        // a click landing on the expiry cycle still counts as a double
                        if (btn_click) begin
                            state        <= SWALLOW;
                            cnt          <= '0;
                            double_press <= 1'b1;
                        end else if (cnt_inc == CNT_WIDTH'(DBL_WINDOW)) begin
                            state       <= IDLE;
                            cnt         <= '0;
                            short_press <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    SWALLOW: begin
                        if (!btn_level) state <= IDLE;
                    end
`endif
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                        held  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder (LONG=8, REPEAT=4, DBL_WINDOW=6).
module tb_button_event_decoder;
    logic clk = 1'b0;
    logic rst, ce, btn_level, btn_click;
    logic short_press, long_press, repeat_tick, double_press, held;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    button_event_decoder #(
        .CNT_WIDTH(16), .LONG_CYCLES(8), .REPEAT_CYCLES(4), .DBL_WINDOW(6)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .btn_level(btn_level), .btn_click(btn_click),
        .short_press(short_press), .long_press(long_press), .repeat_tick(repeat_tick),
        .double_press(double_press), .held(held)
    );

    // {short, long, repeat, double, held}
    wire [4:0] obs = {short_press, long_press, repeat_tick, double_press, held};

    // Drive one clk worth of inputs; after return, obs holds the value for the next cycle.
    task automatic drive(input logic r, input logic lvl, input logic clk_in, input logic ce_in);
        rst = r; btn_level = lvl; btn_click = clk_in; ce = ce_in;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset;
        logic [4:0] exp;
        exp = 5'b0;
        for (int c = 0; c < 2; c++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b1);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset cyc %0d: got %b exp %b", c, obs, exp);
            end
        end
        for (int c = 0; c < 20; c++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b1);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_level_held cyc %0d: got %b exp %b", c, obs, exp);
            end
        end
        idle(2);
    endtask

    task automatic test_short;
        logic [4:0] exp;
        int n, sp_cyc;
`ifdef BTN_DOUBLE_CLICK_EN
        sp_cyc = 11;
`else
        sp_cyc = 5;
`endif
        for (int c = 0; c < 14; c++) begin
            drive(1'b0, c <= 3, c == 0, 1'b1);
            n = c + 1;
            exp = (n == sp_cyc) ? 5'b10000 : 5'b00000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL short cyc %0d: got %b exp %b", n, obs, exp);
            end
        end
        idle(2);
    endtask

    task automatic test_long_repeat;
        logic [4:0] exp;
        int n;
        for (int c = 0; c < 26; c++) begin
            drive(1'b0, c <= 20, c == 0, 1'b1);
            n = c + 1;
            exp = {1'b0, n == 9, n == 13 || n == 17 || n == 21, 1'b0, n >= 9 && n <= 21};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL long_repeat cyc %0d: got %b exp %b", n, obs, exp);
            end
        end
        idle(2);
    endtask

    task automatic test_ce;
        logic [4:0] exp;
        int n;
        for (int c = 0; c < 50; c++) begin
            drive(1'b0, c <= 40, c == 0, (c % 2) == 0);
            n = c + 1;
            exp = {1'b0, n == 17, n == 25 || n == 33 || n == 41, 1'b0, n >= 17 && n <= 42};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL ce_gated cyc %0d: got %b exp %b", n, obs, exp);
            end
        end
        idle(2);
    endtask

    task automatic test_reset_mid_press;
        logic [4:0] exp;
        int n;
        for (int c = 0; c < 22; c++) begin
            drive(c == 5, c <= 19, c == 0 || c == 8, 1'b1);
            n = c + 1;
            exp = {1'b0, n == 17, 1'b0, 1'b0, n >= 17 && n <= 20};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_mid_press cyc %0d: got %b exp %b", n, obs, exp);
            end
        end
        idle(2);
    endtask

    task automatic test_click_while_pressed;
        logic [4:0] exp;
        int n;
        for (int c = 0; c < 12; c++) begin
            drive(1'b0, c <= 10, c == 0 || c == 3, 1'b1);
            n = c + 1;
            exp = {1'b0, n == 9, 1'b0, 1'b0, n >= 9 && n <= 11};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL click_while_pressed cyc %0d: got %b exp %b", n, obs, exp);
            end
        end
        idle(2);
    endtask

`ifdef BTN_DOUBLE_CLICK_EN
    task automatic test_double;
        logic [4:0] exp;
        int n;
        // second click 3 cycles after release, then held long: no long_press
        for (int c = 0; c < 31; c++) begin
            drive(1'b0, c <= 3 || (c >= 7 && c <= 27), c == 0 || c == 7, 1'b1);
            n = c + 1;
            exp = (n == 8) ? 5'b00010 : 5'b00000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL double cyc %0d: got %b exp %b", n, obs, exp);
            end
        end
        idle(2);
        // click on the window-expiry cycle: double wins
        for (int c = 0; c < 16; c++) begin
            drive(1'b0, c <= 3 || (c >= 10 && c <= 12), c == 0 || c == 10, 1'b1);
            n = c + 1;
            exp = (n == 11) ? 5'b00010 : 5'b00000;
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL double_at_expiry cyc %0d: got %b exp %b", n, obs, exp);
            end
        end
        idle(2);
    endtask
`endif

    initial begin
        rst = 1'b1; ce = 1'b1; btn_level = 1'b1; btn_click = 1'b0;
        test_reset();
        test_short();
        test_long_repeat();
        test_ce();
        test_reset_mid_press();
        test_click_while_pressed();
`ifdef BTN_DOUBLE_CLICK_EN
        test_double();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
